// File: rtl/rr_sel_mux_if.sv
// Operand-selector bus: N_CH producer channels in, one registered word out.
// Producers and consumer use valid/ready; the selector sits on the slave side.
interface rr_sel_mux_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SW = $clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  mode;
  logic [SW-1:0]         sel;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SW-1:0]         out_ch;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, mode, sel, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, mode, sel, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_sel_mux.sv
// Registered N:1 operand selector (round-robin or fixed sel), 1-cycle latency.
// One-entry output register; in_ready drops while the held word is stalled.
module rr_sel_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_sel_mux_if.slave  bus
);
  localparam int SW = $clog2(N_CH);

  logic [SW-1:0]    ptr;
  logic [SW-1:0]    gidx;
  logic [N_CH-1:0]  grant;
  logic [WIDTH-1:0] gdat;
  logic             found;
  logic             space;
  logic             xfer;

  logic             vld_q;
  logic [WIDTH-1:0] dat_q;
  logic [SW-1:0]    ch_q;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    if (!bus.mode) begin
      // Scan offsets from farthest to nearest so the nearest valid channel after ptr wins.
      for (int k = N_CH; k >= 1; k--) begin
        for (int i = 0; i < N_CH; i++) begin
          if (bus.in_valid[i] && (i == ((int'(ptr) + k) % N_CH))) begin
            found = 1'b1;
            gidx  = SW'(i);
          end
        end
      end
    end else begin
      // An out-of-range sel matches no channel and so yields no grant.
      for (int i = 0; i < N_CH; i++) begin
        if (bus.in_valid[i] && (bus.sel == SW'(i))) begin
          found = 1'b1;
          gidx  = SW'(i);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    gdat  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (found && (gidx == SW'(i))) begin
        grant[i] = 1'b1;
        gdat     = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign space        = ~vld_q | bus.out_ready;
  assign xfer         = found & space & ~rst;
  assign bus.in_ready = grant & {N_CH{xfer}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      ch_q  <= '0;
      ptr   <= SW'(N_CH - 1);
    end else if (xfer) begin
      vld_q <= 1'b1;
      dat_q <= gdat;
      ch_q  <= gidx;
      if (!bus.mode) begin
        ptr <= gidx;
      end
    end else if (bus.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = dat_q;
  assign bus.out_ch    = ch_q;
endmodule
